// File: rtl/switch_debounce.sv
// switch_debounce
// Synchronizes and debounces raw slide-switch levels ahead of the SoC GPIO
// input. Each channel has its own 2-flop synchronizer, a two-state
// STABLE/COUNTING FSM and a saturating hold counter. The FSM emits
// single-cycle rise/fall pulses when a new level has been held long enough.
//
// Optional feature macro: SWDEB_EVT_IRQ_EN
//   defined   - sticky per-bit evt_pending (write-1-to-clear via evt_ack, set
//               wins over ack) and a registered irq = |evt_pending
//   undefined - evt_pending and irq are constant 0, evt_ack is ignored, and
//               no flops are built for that logic
module switch_debounce #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             RSTn,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    input  logic [WIDTH-1:0] evt_ack,
    output logic [WIDTH-1:0] evt_pending,
    output logic             irq
);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } state_e;

    // Count value at which a held mismatch is accepted as the new level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Counter increment that pins at the accept value so it can never wrap.
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
        return (c >= CNT_LAST) ? CNT_LAST : (c + CNT_ONE);
    endfunction

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    state_e           state_q [WIDTH];
    state_e           state_d [WIDTH];
    logic [CNT_W-1:0] cnt_q   [WIDTH];
    logic [CNT_W-1:0] cnt_d   [WIDTH];

    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] rise_q,   rise_d;
    logic [WIDTH-1:0] fall_q,   fall_d;

    // Two-flop synchronizer bringing the asynchronous switch pins into clk.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw_in;
            sync2_q <= sync1_q;
        end
    end

    // Per-channel debounce FSM: next state, counter, accepted level and pulses.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
        end
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;

        for (int i = 0; i < WIDTH; i++) begin
            case (state_q[i])
                ST_STABLE: begin
                    if (sync2_q[i] != stable_q[i]) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            // A one-cycle hold is satisfied by the first mismatch.
                            stable_d[i] = sync2_q[i];
                            rise_d[i]   = sync2_q[i];
                            fall_d[i]   = ~sync2_q[i];
                            cnt_d[i]    = '0;
                        end else begin
                            state_d[i] = ST_COUNTING;
                            cnt_d[i]   = CNT_ONE;
                        end
                    end
                end
                ST_COUNTING: begin
                    if (sync2_q[i] == stable_q[i]) begin
                        // Input bounced back before the hold time: forget it.
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        stable_d[i] = sync2_q[i];
                        rise_d[i]   = sync2_q[i];
                        fall_d[i]   = ~sync2_q[i];
                        state_d[i]  = ST_STABLE;
                        cnt_d[i]    = '0;
                    end else begin
                        cnt_d[i] = cnt_sat_inc(cnt_q[i]);
                    end
                end
            endcase
        end
    end

    // State, counters, accepted level and edge pulses; reset discards any count.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end
            stable_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign sw_stable = stable_q;
    assign sw_rise   = rise_q;
    assign sw_fall   = fall_q;

`ifdef SWDEB_EVT_IRQ_EN
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             irq_q;

    // Sticky change flags: ack clears, a new edge pulse sets and wins a tie.
    always_comb begin
        pend_d = (pend_q & ~evt_ack) | rise_q | fall_q;
    end

    // Pending register and the interrupt, which lags pending by one cycle.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            pend_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            irq_q  <= |pend_q;
        end
    end

    assign evt_pending = pend_q;
    assign irq         = irq_q;
`else
    // Acknowledge has nothing to act on when the event logic is not built.
    logic [WIDTH-1:0] unused_evt_ack;
    assign unused_evt_ack = evt_ack;
    assign evt_pending    = '0;
    assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce (WIDTH=8, DEBOUNCE_CYCLES=4).
// Expected outputs are queued when stimulus is applied and popped one entry
// per clock as the DUT advances. Pending/irq expectations collapse to 0 when
// SWDEB_EVT_IRQ_EN is not defined.
module tb_switch_debounce;

    localparam int W = 8;

`ifdef SWDEB_EVT_IRQ_EN
    localparam bit EVT_EN = 1'b1;
`else
    localparam bit EVT_EN = 1'b0;
`endif

    logic         clk;
    logic         RSTn;
    logic [W-1:0] sw_in;
    logic [W-1:0] sw_stable;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic [W-1:0] evt_ack;
    logic [W-1:0] evt_pending;
    logic         irq;

    switch_debounce #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (20)
    ) dut (
        .clk        (clk),
        .RSTn       (RSTn),
        .sw_in      (sw_in),
        .sw_stable  (sw_stable),
        .sw_rise    (sw_rise),
        .sw_fall    (sw_fall),
        .evt_ack    (evt_ack),
        .evt_pending(evt_pending),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        logic [W-1:0] st;
        logic [W-1:0] ri;
        logic [W-1:0] fa;
        logic [W-1:0] pe;
        logic         iq;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [W-1:0] st, input logic [W-1:0] ri,
                        input logic [W-1:0] fa, input logic [W-1:0] pe, input logic iq,
                        input int n);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.ri  = ri;
        e.fa  = fa;
        e.pe  = EVT_EN ? pe : '0;
        e.iq  = EVT_EN ? iq : 1'b0;
        for (int k = 0; k < n; k++) sb.push_back(e);
    endtask

    task automatic compare_front();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".stable"},  {24'd0, sw_stable},   {24'd0, e.st});
            chk({e.tag, ".rise"},    {24'd0, sw_rise},     {24'd0, e.ri});
            chk({e.tag, ".fall"},    {24'd0, sw_fall},     {24'd0, e.fa});
            chk({e.tag, ".pending"}, {24'd0, evt_pending}, {24'd0, e.pe});
            chk({e.tag, ".irq"},     {31'd0, irq},         {31'd0, e.iq});
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            compare_front();
        end
    endtask

    initial begin
        RSTn    = 1'b0;
        sw_in   = '0;
        evt_ack = '0;

        // Reset state
        push("reset", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 3);
        step(3);
        RSTn = 1'b1;
        push("idle", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 2);
        step(2);

        // Clean rise on bit 0
        sw_in = 8'h01;
        push("rise_lat",  8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 5);
        push("rise_edge", 8'h01, 8'h01, 8'h00, 8'h00, 1'b0, 1);
        push("rise_pend", 8'h01, 8'h00, 8'h00, 8'h01, 1'b0, 1);
        push("rise_irq",  8'h01, 8'h00, 8'h00, 8'h01, 1'b1, 2);
        step(9);

        // Acknowledge clears pending; irq follows a cycle later
        evt_ack = 8'h01;
        push("ack0_clr", 8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 1);
        step(1);
        evt_ack = 8'h00;
        push("ack0_irq", 8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 1);
        step(1);

        // Bounce on bit 3: 3-cycle levels never reach the 4-cycle hold
        for (int b = 0; b < 4; b++) begin
            sw_in = (b % 2 == 0) ? 8'h09 : 8'h01;
            push("bounce", 8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 3);
            step(3);
        end
        sw_in = 8'h01;
        push("bounce_hold", 8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 8);
        step(8);

        // Bring all channels high: seven concurrent rises
        sw_in = 8'hFF;
        push("ff_lat",  8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 5);
        push("ff_edge", 8'hFF, 8'hFE, 8'h00, 8'h00, 1'b0, 1);
        push("ff_pend", 8'hFF, 8'h00, 8'h00, 8'hFE, 1'b0, 1);
        push("ff_irq",  8'hFF, 8'h00, 8'h00, 8'hFE, 1'b1, 1);
        step(8);
        evt_ack = 8'hFE;
        push("ackfe_clr", 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 1);
        step(1);
        evt_ack = 8'h00;
        push("ackfe_irq", 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 1);
        step(1);

        // Fall on the upper nibble, concurrent channels
        sw_in = 8'h0F;
        push("fall_lat",  8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 5);
        push("fall_edge", 8'h0F, 8'h00, 8'hF0, 8'h00, 1'b0, 1);
        push("fall_pend", 8'h0F, 8'h00, 8'h00, 8'hF0, 1'b0, 1);
        push("fall_irq",  8'h0F, 8'h00, 8'h00, 8'hF0, 1'b1, 1);
        step(8);

        // Ack of bit 0 coincides with its set: set wins
        sw_in = 8'h0E;
        push("col_lat",  8'h0F, 8'h00, 8'h00, 8'hF0, 1'b1, 5);
        push("col_edge", 8'h0E, 8'h00, 8'h01, 8'hF0, 1'b1, 1);
        step(6);
        evt_ack = 8'h01;
        push("col_setwins", 8'h0E, 8'h00, 8'h00, 8'hF1, 1'b1, 1);
        step(1);
        evt_ack = 8'h02;
        push("ack_clear_bit", 8'h0E, 8'h00, 8'h00, 8'hF1, 1'b1, 1);
        step(1);
        evt_ack = 8'hF1;
        push("ack_all", 8'h0E, 8'h00, 8'h00, 8'h00, 1'b1, 1);
        step(1);
        evt_ack = 8'h00;
        push("irq_drop", 8'h0E, 8'h00, 8'h00, 8'h00, 1'b0, 2);
        step(2);

        // Reset asserted while bit 7 count is at 2
        sw_in = 8'h80;
        push("mid_lat", 8'h0E, 8'h00, 8'h00, 8'h00, 1'b0, 4);
        step(4);
        RSTn = 1'b0;
        #1;
        push("rst_async", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1);
        compare_front();
        push("rst_hold", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 2);
        step(2);
        RSTn = 1'b1;
        push("rst_lat",  8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 5);
        push("rst_edge", 8'h80, 8'h80, 8'h00, 8'h00, 1'b0, 1);
        push("rst_pend", 8'h80, 8'h00, 8'h00, 8'h80, 1'b0, 1);
        push("rst_irq",  8'h80, 8'h00, 8'h00, 8'h80, 1'b1, 1);
        step(8);

        chk("sb_drain", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/switch_debounce.md
# switch_debounce

Debounces and synchronizes the raw board slide switches before they reach the Cortex-M0 SoC GPIO input port. Produces clean stable levels, single-cycle rise and fall pulses, and an optional sticky per-bit change flag with write-1-to-clear acknowledge and an aggregated interrupt line. It sits between the switch pins and `io_pin0` of the SoC, one stage upstream of the GPIO block.

## Interface
- `WIDTH`, 8: number of switch channels.
- `DEBOUNCE_CYCLES`, 1000000: consecutive cycles the new level must hold before it is accepted. Legal range is 1 to 2^`CNT_W`-1.
- `CNT_W`, 20: width of each per-channel counter.

- `clk`  in  1  system clock.
- `RSTn`  in  1  asynchronous active-low reset.
- `sw_in`  in  WIDTH  raw switch levels; asynchronous and bouncy.
- `sw_stable`  out  WIDTH  debounced level, registered.
- `sw_rise`  out  WIDTH  one-cycle pulse when `sw_stable[i]` goes 0->1.
- `sw_fall`  out  WIDTH  one-cycle pulse when `sw_stable[i]` goes 1->0.
- `evt_ack`  in  WIDTH  write-1-to-clear strobe for `evt_pending`.
- `evt_pending`  out  WIDTH  sticky flag, set by any debounced edge.
- `irq`  out  1  OR-reduction of `evt_pending`, registered.

## Operation
- **Synchronizer:** a 2-flop synchronizer per bit converts `sw_in` into `sw_sync`.
- **Per-channel FSM (2 states):**
  - STABLE: `sw_sync[i] == sw_stable[i]` and `cnt[i] = 0`.
  - COUNTING: `sw_sync[i] != sw_stable[i]`.
- **Transitions:**
  - In STABLE, a mismatch moves the channel to COUNTING and sets `cnt` to 1.
  - In COUNTING, a match (bounce back) returns to STABLE with `cnt` set to 0.
  - In COUNTING, a mismatch with `cnt == DEBOUNCE_CYCLES-1` sets `sw_stable[i] <= sw_sync[i]`, pulses `sw_rise[i]` or `sw_fall[i]`, sets `cnt` to 0 and returns to STABLE.
  - In COUNTING, any other mismatch increments `cnt`.
- **`DEBOUNCE_CYCLES = 1`:** `sw_stable` follows `sw_sync` one cycle later.
- **Counter width:** the counter never wraps, because it saturates at the compare value.
- **Channel independence:** channels are fully independent. Several bits may update in the same cycle.
- **Pending flag:**
  - `evt_pending[i]` is set on `sw_rise[i] | sw_fall[i]`.
  - It is cleared on `evt_ack[i]`.
  - Simultaneous set and ack leaves it set (set wins).
  - Acking a bit that is already clear has no effect.
- **`irq`:** registered `|evt_pending`; it lags `evt_pending` by one cycle.
- **Reset values:**
  - Synchronizer flops, `sw_stable`, `sw_rise`, `sw_fall`, all `cnt`, `evt_pending` and `irq` are all 0.
  - Reset asserted mid-count immediately discards the count.
  - A switch held high through reset produces a `sw_rise` after the normal latency.

## Timing
- **Input to stable latency:** `sw_in` is first sampled at the new level on edge E0. `sw_sync` shows it after E1. `sw_stable` changes on edge E1+`DEBOUNCE_CYCLES`, which is `DEBOUNCE_CYCLES`+1 edges after E0.
- **Edge pulses:** `sw_rise`/`sw_fall` are registered on the same edge as `sw_stable` and are high for exactly one cycle.
- **Pending and interrupt:** `evt_pending` sets one edge after the pulse. `irq` follows one edge after `evt_pending`.
- **Glitch rejection:** a glitch shorter than `DEBOUNCE_CYCLES` cycles at `sw_sync` never changes `sw_stable`.
- **Reset behaviour:** assertion is asynchronous; deassertion is used synchronously by the internal logic. No outputs are combinational from inputs.

## Configuration
- **`SWDEB_EVT_IRQ_EN` defined:** the `evt_pending`, `evt_ack` and `irq` logic is built as described above.
- **`SWDEB_EVT_IRQ_EN` undefined:**
  - `evt_pending` and `irq` are tied to constant 0.
  - `evt_ack` is ignored.
  - No flops are generated for the pending or interrupt logic.
  - Debounce, `sw_stable` and the edge pulses are unchanged.

## Test plan
All scenarios use `DEBOUNCE_CYCLES = 4`, `WIDTH = 8`, and are run with the macro defined unless stated otherwise.
- **Clean rise:** reset, then `sw_in` = 0x00 -> 0x01 held. Required: `sw_stable` = 0x01 exactly 5 edges after the first sampling edge, with a single-cycle `sw_rise` = 0x01, `evt_pending` = 0x01 one edge later, and `irq` = 1 one edge after that.
- **Bounce rejection:** toggle `sw_in[3]` 1,0,1,0 with each level held for 3 cycles, then hold 0. Required: `sw_stable` stays 0x00, `sw_rise`/`sw_fall` never assert, `evt_pending` stays 0x00.
- **Fall and concurrent channels:** with `sw_stable` = 0xFF, drive `sw_in` to 0x0F. Required: `sw_stable` = 0x0F after the latency, with `sw_fall` = 0xF0 for one cycle and `sw_rise` = 0x00.
- **Ack vs set collision:** assert `evt_ack[0]` in the same cycle that `evt_pending[0]` would be set. Required: `evt_pending[0]` remains 1. A later `evt_ack` = 0x01 clears it, and `irq` drops one cycle after that.
- **Reset mid-count:** drop `RSTn` when `cnt` = 2 with `sw_in` = 0x80. Required: all outputs are 0 immediately. After release, `sw_stable` = 0x80 only after a full 5-edge latency, with `sw_rise` = 0x80.
- **Macro off:** repeat the clean-rise scenario with `SWDEB_EVT_IRQ_EN` undefined. Required: `sw_stable`/`sw_rise` are identical to the first scenario, and `evt_pending` = 0x00, `irq` = 0 throughout.
